seq_divider: RTL and testbench

//  Parametrised radix-2 restoring divider with a start/done handshake. Returns quotient and remainder.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 39 +++
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the seq_divider block:
//   - state_t     : divider controller states (IDLE, CALC, DONE)
//   - STATE_W     : width of the state encoding
//   - DIV_ZERO_Q  : quotient fill pattern reported on divide-by-zero
//                   (sliced to the operand width, so W must not exceed 64)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-ones quotient; in two's complement this also reads as -1.
    localparam logic [63:0] DIV_ZERO_Q = {64{1'b1}};

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division step:
//   {rem, q} is shifted left by one, then the divisor is subtracted from the
//   partial remainder when it fits and the freed quotient LSB records that.
// Ports:
//   rem_in  [W:0]   partial remainder before the step (always < divisor)
//   q_in    [W-1:0] quotient/dividend shift register before the step
//   divisor [W-1:0] denominator magnitude
//   rem_out [W:0]   partial remainder after the step
//   q_out   [W-1:0] quotient/dividend shift register after the step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic [W-1:0] q_out
);

    logic [W+1:0] w_shift;
    logic         w_ge;

    always_comb begin
        // The shifted value is kept one bit wider than the remainder so the
        // compare never loses the bit shifted out of the top.
        w_shift = {rem_in, q_in[W-1]};
        w_ge    = (w_shift >= {2'b00, divisor});
        // When the subtraction happens the result is below the divisor, so
        // dropping the top bit of the shifted value is lossless.
        rem_out = w_ge ? (w_shift[W:0] - {1'b0, divisor}) : w_shift[W:0];
        q_out   = {q_in[W-2:0], w_ge};
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Parametrised radix-2 restoring divider with a start/done handshake.
// A division takes W+1 cycles from the accepting edge to the done pulse;
// a zero divisor finishes in one cycle and raises div_by_zero.
//
// Build option:
//   DIV_SIGNED_EN  defined   -> two's complement operands and results
//                            (quotient truncates toward zero, remainder
//                            takes the dividend's sign)
//                  undefined -> unsigned only, no sign logic
//
// Ports:
//   clk          in   1  rising-edge clock
//   clr_n        in   1  synchronous active-low reset
//   start        in   1  request, only honoured while busy=0
//   dividend     in   W  numerator, captured on an accepted start
//   divisor      in   W  denominator, captured on an accepted start
//   busy         out  1  division in progress
//   done         out  1  one-cycle pulse, results valid
//   quotient     out  W  result, held between completions
//   remainder    out  W  result, held between completions
//   div_by_zero  out  1  set with done for a zero divisor
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(W + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [W:0]         r_rem;
    logic [W-1:0]       r_q;
    logic [W-1:0]       r_div;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last_step;
    logic [W-1:0]       w_dvd_mag;
    logic [W-1:0]       w_dsr_mag;
    logic [W:0]         w_rem_out;
    logic [W-1:0]       w_q_out;
    logic [W-1:0]       w_q_fix;
    logic [W-1:0]       w_r_fix;

    assign w_div_zero  = (divisor == '0);
    assign w_last_step = (r_cnt == CNT_W'(1));

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Magnitudes are taken at capture; the most negative value maps to
    // 2^(W-1), which still fits in W unsigned bits.
    assign w_dvd_mag = dividend[W-1] ? -dividend : dividend;
    assign w_dsr_mag = divisor[W-1]  ? -divisor  : divisor;
    // Sign fix-up sits on the result-register input, so latency is unchanged.
    // -2^(W-1) / -1 naturally wraps back to -2^(W-1) here.
    assign w_q_fix   = r_neg_q ? -w_q_out : w_q_out;
    assign w_r_fix   = r_neg_r ? -w_rem_out[W-1:0] : w_rem_out[W-1:0];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= dividend[W-1] ^ divisor[W-1];
            r_neg_r <= dividend[W-1];
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dsr_mag = divisor;
    assign w_q_fix   = w_q_out;
    assign w_r_fix   = w_rem_out[W-1:0];
`endif

    div_step #(
        .W (W)
    ) u_step (
        .rem_in  (r_rem),
        .q_in    (r_q),
        .divisor (r_div),
        .rem_out (w_rem_out),
        .q_out   (w_q_out)
    );

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start here is accepted immediately (no idle bubble).
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_rem       <= '0;
            r_q         <= w_dvd_mag;
            r_div       <= w_dsr_mag;
            r_cnt       <= CNT_W'(W);
            div_by_zero <= w_div_zero;
            // Zero divisor completes on the very next cycle, so its results
            // are written right away; otherwise results wait for the last step.
            if (w_div_zero) begin
                quotient  <= DIV_ZERO_Q[W-1:0];
                remainder <= dividend;
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_out;
            r_q   <= w_q_out;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last_step) begin
                quotient  <= w_q_fix;
                remainder <= w_r_fix;
            end
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed literal cases plus a randomized sweep. A behavioural model tracks
// the expected handshake timing and results from plain arithmetic and is
// compared against the DUT on every falling edge.
// Build option DIV_SIGNED_EN selects W=8 signed, otherwise W=16 unsigned.
// -----------------------------------------------------------------------------
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
    localparam int W = 8;
`else
    localparam int W = 16;
`endif

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint sa;
        longint sb;
`ifdef DIV_SIGNED_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_z = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] p_q = '0;
    logic [W-1:0] p_r = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        logic [W-1:0] tq;
        logic [W-1:0] tr;
        logic         tz;
        if (!clr_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_z    = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_left = 0;
        end else if (start && !m_busy) begin
            ref_div(dividend, divisor, tq, tr, tz);
            m_z = tz;
            if (tz) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = tq;
                m_r    = tr;
            end else begin
                m_busy = 1'b1;
                m_done = 1'b0;
                m_left = W;
                p_q    = tq;
                p_r    = tr;
            end
        end else if (m_busy) begin
            m_done = 1'b0;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = p_q;
                m_r    = p_r;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", W'(busy), W'(m_busy));
            check("done", W'(done), W'(m_done));
            check("div_by_zero", W'(div_by_zero), W'(m_z));
            if (!m_busy) begin
                check("quotient", quotient, m_q);
                check("remainder", remainder, m_r);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Issue one divide from an idle DUT and check literal results and latency
    // (cycle 1 = first cycle after the accepting edge).
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int elat);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check_int({name, " latency"}, n, elat);
        check({name, " q"}, quotient, eq);
        check({name, " r"}, remainder, er);
        check({name, " z"}, W'(div_by_zero), W'(ez));
        $display("[TB] %s: %0h / %0h -> q=%0h r=%0h z=%0b after %0d cycles",
                 name, a, b, quotient, remainder, div_by_zero, n);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [W-1:0] tq;
        logic [W-1:0] tr;
        logic         tz;
        int           n;
        bit           saw_done;

        // Pin the reference arithmetic itself.
        ref_div(W'(100), W'(7), tq, tr, tz);
        check("model 100/7 q", tq, W'(14));
        check("model 100/7 r", tr, W'(2));
        ref_div(W'(5), W'(0), tq, tr, tz);
        check("model 5/0 q", tq, {W{1'b1}});
        check("model 5/0 z", W'(tz), W'(1));

        // Reset state.
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset q", quotient, W'(0));
        check("reset r", remainder, W'(0));
        check("reset z", W'(div_by_zero), W'(0));
        clr_n = 1'b1;

        run_op("100/7", W'(100), W'(7), W'(14), W'(2), 1'b0, W + 1);
        run_op("5/0", W'(5), W'(0), {W{1'b1}}, W'(5), 1'b1, 1);
        run_op("9/3", W'(9), W'(3), W'(3), W'(0), 1'b0, W + 1);
        run_op("3/10", W'(3), W'(10), W'(0), W'(3), 1'b0, W + 1);
`ifdef DIV_SIGNED_EN
        run_op("-7/2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, W + 1);
        run_op("7/-2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, W + 1);
        run_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, W + 1);
        run_op("-5/0", 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1);
`else
        run_op("FFFF/1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, W + 1);
`endif

        // Back-to-back issue with start held high throughout.
        @(negedge clk);
        dividend = W'(40);
        divisor  = W'(6);
        start    = 1'b1;
        @(negedge clk);
        dividend = W'(81);
        divisor  = W'(9);
        wait_done(n);
        check_int("b2b first latency", n, W + 1);
        check("b2b first q", quotient, W'(6));
        check("b2b first r", remainder, W'(4));
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_int("b2b gap", n, W + 1);
        check("b2b second q", quotient, W'(9));
        check("b2b second r", remainder, W'(0));
        $display("[TB] back-to-back: second done %0d cycles after first, q=%0h r=%0h",
                 n, quotient, remainder);

        // Reset in the 5th CALC cycle aborts the divide.
        @(negedge clk);
        dividend = W'(100);
        divisor  = W'(7);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("abort busy", W'(busy), W'(0));
        check("abort q", quotient, W'(0));
        check("abort r", remainder, W'(0));
        saw_done = 1'b0;
        repeat (W + 3) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("abort no done", W'(saw_done), W'(0));
        $display("[TB] mid-divide reset: busy=%0b done_seen=%0b", busy, saw_done);
        run_op("after abort 100/7", W'(100), W'(7), W'(14), W'(2), 1'b0, W + 1);

        // Randomized sweep: random starts (many while busy), random operands,
        // occasional zero/small divisors and rare resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1, 2:    divisor = W'($urandom_range(1, 7));
                3:       divisor = {W{1'b1}};
                default: divisor = W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) dividend = {1'b1, {(W-1){1'b0}}};
            clr_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        clr_n = 1'b1;
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_divider
